// File: rtl/pipe_mul_if.sv
// Request/response bundle for the pipelined multiplier: issue side, stall/flush controls and the
// tagged result.
interface pipe_mul_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       op_i;
  logic             word_i;
  logic [XLEN-1:0]  op_1_i;
  logic [XLEN-1:0]  op_2_i;
  logic [TAG_W-1:0] tag_i;
  logic             block_i;
  logic             flush_i;
  logic             out_valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output req_valid_i, op_i, word_i, op_1_i, op_2_i, tag_i, block_i, flush_i,
    input  req_ready_o, out_valid_o, result_o, tag_o
  );

  modport slave (
    input  req_valid_i, op_i, word_i, op_1_i, op_2_i, tag_i, block_i, flush_i,
    output req_ready_o, out_valid_o, result_o, tag_o
  );
endinterface

// File: rtl/pipe_mul.sv
// Fully pipelined RISC-V MUL/MULH/MULHSU/MULHU (+ optional MULW) with tag pass-through, whole-pipe
// stall and flush. The product is formed at issue and carried through LATENCY register stages.
module pipe_mul #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned WORD_EN = 1
) (
  input logic       clk,
  input logic       rst,
  pipe_mul_if.slave bus
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned WBits = (XLEN < 32) ? XLEN : 32;
  localparam int unsigned Last  = LATENCY - 1;

  logic            accept;
  logic            word_eff;
  logic            a_sign;
  logic            b_sign;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   b_ext;
  logic [PW-1:0]   a_wide;
  logic [PW-1:0]   b_wide;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] result;

  logic [LATENCY-1:0] vld_q;
  logic [PW-1:0]      prod_q [LATENCY];
  logic [1:0]         op_q   [LATENCY];
  logic               word_q [LATENCY];
  logic [TAG_W-1:0]   tag_q  [LATENCY];

  assign bus.req_ready_o = ~bus.block_i;
  assign accept          = bus.req_valid_i & ~bus.block_i & ~bus.flush_i;

  always_comb begin
    word_eff = (WORD_EN != 0) && bus.word_i;
    a_sign   = (bus.op_i != 2'b11);
    b_sign   = ~bus.op_i[1];
    a_ext    = {a_sign & bus.op_1_i[XLEN-1], bus.op_1_i};
    b_ext    = {b_sign & bus.op_2_i[XLEN-1], bus.op_2_i};
    if (word_eff) begin
      a_ext = {{(XLEN + 1 - WBits){bus.op_1_i[WBits-1]}}, bus.op_1_i[WBits-1:0]};
      b_ext = {{(XLEN + 1 - WBits){bus.op_2_i[WBits-1]}}, bus.op_2_i[WBits-1:0]};
    end
    // Sign-extending to 2*XLEN makes a plain modular multiply give the signed product.
    a_wide = {{(XLEN - 1){a_ext[XLEN]}}, a_ext};
    b_wide = {{(XLEN - 1){b_ext[XLEN]}}, b_ext};
    prod   = a_wide * b_wide;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        prod_q[i] <= '0;
        op_q[i]   <= '0;
        word_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (bus.flush_i) begin
      vld_q <= '0;
    end else if (!bus.block_i) begin
      vld_q[0] <= accept;
      if (accept) begin
        prod_q[0] <= prod;
        op_q[0]   <= bus.op_i;
        word_q[0] <= word_eff;
        tag_q[0]  <= bus.tag_i;
      end
      // Data only moves with a valid op, so the last stage holds the previous result when idle.
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          prod_q[i] <= prod_q[i-1];
          op_q[i]   <= op_q[i-1];
          word_q[i] <= word_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end
  end

  always_comb begin
    if (op_q[Last] == 2'b00) begin
      result = prod_q[Last][XLEN-1:0];
    end else begin
      result = prod_q[Last][PW-1:XLEN];
    end
    if (word_q[Last]) begin
      result = prod_q[Last][XLEN-1:0];
      for (int i = int'(WBits); i < int'(XLEN); i++) begin
        result[i] = prod_q[Last][WBits-1];
      end
    end
  end

  assign bus.out_valid_o = vld_q[Last];
  assign bus.result_o    = result;
  assign bus.tag_o       = tag_q[Last];

endmodule

// File: tb/tb_pipe_mul.sv
// Directed bench for pipe_mul: 64-bit/LATENCY=3 instance for ops, stall, flush and reset, plus a
// 32-bit/LATENCY=1/no-word instance checked with directed vectors and a 64-bit arithmetic model.
module tb_pipe_mul;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_mul_if #(.XLEN(64), .TAG_W(5)) bus ();
  pipe_mul_if #(.XLEN(32), .TAG_W(5)) bus32 ();

  pipe_mul #(.XLEN(64), .LATENCY(3), .TAG_W(5), .WORD_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pipe_mul #(.XLEN(32), .LATENCY(1), .TAG_W(5), .WORD_EN(0)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;  bus.op_i = 2'b00;  bus.word_i = 1'b0;
    bus.op_1_i = '0;  bus.op_2_i = '0;  bus.tag_i = '0;
    bus.block_i = 1'b0;  bus.flush_i = 1'b0;
    bus32.req_valid_i = 1'b0;  bus32.op_i = 2'b00;  bus32.word_i = 1'b0;
    bus32.op_1_i = '0;  bus32.op_2_i = '0;  bus32.tag_i = '0;
    bus32.block_i = 1'b0;  bus32.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.result_o !== 64'd0 || bus.tag_o !== 5'd0) begin
      failures++;
      $display("FAIL reset64: valid=%b result=%h tag=%0d, expected 0/0/0",
               bus.out_valid_o, bus.result_o, bus.tag_o);
    end
    checks++;
    if (bus32.out_valid_o !== 1'b0 || bus32.result_o !== 32'd0 || bus32.tag_o !== 5'd0) begin
      failures++;
      $display("FAIL reset32: valid=%b result=%h tag=%0d, expected 0/0/0",
               bus32.out_valid_o, bus32.result_o, bus32.tag_o);
    end
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle: got %b expected 1", bus.req_ready_o);
    end
    bus.block_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL ready_block: got %b expected 0", bus.req_ready_o);
    end
    bus.block_i = 1'b0;
    tick();
  endtask

  // Issue in cycle 0; expect a single pulse in cycle 3 and a held result in cycle 4.
  task automatic run_one(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp,
                         input string name);
    bus.req_valid_i = 1'b1;  bus.op_i = op;  bus.word_i = w;
    bus.op_1_i = a;  bus.op_2_i = b;  bus.tag_i = tag;
    tick();
    bus.req_valid_i = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus.out_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL %s early_valid cycle %0d: got %b expected 0", name, c, bus.out_valid_o);
      end
      tick();
    end
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.tag_o !== tag) begin
      failures++;
      $display("FAIL %s valid/tag: got %b/%0d expected 1/%0d", name, bus.out_valid_o,
               bus.tag_o, tag);
    end
    checks++;
    if (bus.result_o !== exp) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, bus.result_o, exp);
    end
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.result_o !== exp) begin
      failures++;
      $display("FAIL %s hold: valid=%b result=%h expected 0/%h", name, bus.out_valid_o,
               bus.result_o, exp);
    end
  endtask

  task automatic test_ops();
    run_one(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
            64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones");
    run_one(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
            64'h1, "mul_ones");
    run_one(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
            64'h0, "mulh_m1");
    run_one(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd10,
            64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
    run_one(2'b00, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 5'd11,
            64'hFFFF_FFFF_FFFF_FFFE, "mul_ovf");
    run_one(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 5'd12,
            64'hFFFF_FFFF_FFFF_FFF1, "mul_neg");
    run_one(2'b00, 1'b1, 64'h4000_0000, 64'h2, 5'd13,
            64'hFFFF_FFFF_8000_0000, "mulw");
    run_one(2'b00, 1'b1, 64'hDEAD_BEEF_4000_0000, 64'h1234_5678_0000_0002, 5'd14,
            64'hFFFF_FFFF_8000_0000, "mulw_garbage");
  endtask

  task automatic test_back_to_back();
    int ev[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int et[10] = '{0, 0, 0, 1, 2, 2, 2, 3, 4, 4};
    for (int c = 0; c < 10; c++) begin
      bus.req_valid_i = (c < 4);
      bus.op_i = 2'b00;  bus.word_i = 1'b0;
      bus.tag_i = 5'(c + 1);  bus.op_1_i = 64'(c + 1);  bus.op_2_i = 64'd3;
      bus.block_i = (c == 4 || c == 5);
      #1;
      checks++;
      if (bus.out_valid_o !== ev[c][0]) begin
        failures++;
        $display("FAIL b2b_valid cycle %0d: got %b expected %0d", c, bus.out_valid_o, ev[c]);
      end
      checks++;
      if (bus.req_ready_o !== !(c == 4 || c == 5)) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d: got %b", c, bus.req_ready_o);
      end
      if (c >= 3) begin
        checks++;
        if (bus.tag_o !== 5'(et[c]) || bus.result_o !== 64'(3 * et[c])) begin
          failures++;
          $display("FAIL b2b_data cycle %0d: tag=%0d result=%h expected %0d/%h", c, bus.tag_o,
                   bus.result_o, et[c], 64'(3 * et[c]));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 8; c++) begin
      bus.req_valid_i = (c < 4);
      bus.op_i = 2'b00;  bus.word_i = 1'b0;
      bus.tag_i = 5'(c + 1);  bus.op_1_i = 64'(c + 1);  bus.op_2_i = 64'd5;
      bus.flush_i = (c == 2);
      bus.req_valid_i = (c == 0 || c == 1 || c == 2 || c == 3);
      #1;
      checks++;
      if (bus.out_valid_o !== (c == 6)) begin
        failures++;
        $display("FAIL flush_valid cycle %0d: got %b expected %b", c, bus.out_valid_o, c == 6);
      end
      if (c == 6) begin
        checks++;
        if (bus.tag_o !== 5'd4 || bus.result_o !== 64'd20) begin
          failures++;
          $display("FAIL flush_after: tag=%0d result=%h expected 4/14", bus.tag_o, bus.result_o);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = 1'b1;  bus.op_i = 2'b00;  bus.op_1_i = 64'd9;  bus.op_2_i = 64'd9;
    bus.tag_i = 5'd9;
    tick();
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      checks++;
      if (bus.out_valid_o !== 1'b0 || bus.result_o !== 64'd0 || bus.tag_o !== 5'd0) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: valid=%b result=%h tag=%0d expected 0/0/0", c,
                 bus.out_valid_o, bus.result_o, bus.tag_o);
      end
      tick();
    end
  endtask

  function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00, 2'b01: p = 64'(longint'($signed(a)) * longint'($signed(b)));
      2'b10:        p = 64'(longint'($signed(a)) * longint'({32'd0, b}));
      default:      p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic run32(input logic [1:0] op, input logic w, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                       input string name);
    bus32.req_valid_i = 1'b1;  bus32.op_i = op;  bus32.word_i = w;
    bus32.op_1_i = a;  bus32.op_2_i = b;  bus32.tag_i = tag;
    tick();
    bus32.req_valid_i = 1'b0;
    checks++;
    if (bus32.out_valid_o !== 1'b1 || bus32.tag_o !== tag || bus32.result_o !== exp) begin
      failures++;
      $display("FAIL %s: valid=%b tag=%0d result=%h expected 1/%0d/%h", name,
               bus32.out_valid_o, bus32.tag_o, bus32.result_o, tag, exp);
    end
    tick();
    checks++;
    if (bus32.out_valid_o !== 1'b0 || bus32.result_o !== exp) begin
      failures++;
      $display("FAIL %s hold: valid=%b result=%h expected 0/%h", name, bus32.out_valid_o,
               bus32.result_o, exp);
    end
  endtask

  task automatic test_xlen32();
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    run32(2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, "x32_mulh");
    run32(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, "x32_mulhsu");
    run32(2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, "x32_mulhu");
    run32(2'b00, 1'b0, 32'd12345, 32'd1000, 5'd6, 32'h00BC_5EA8, "x32_mul");
    run32(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0003, 5'd7, 32'h0003_0000, "x32_word_ignored");
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      run32(op, 1'b0, a, b, 5'(i + 16), ref32(op, a, b), "x32_rand");
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
